// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// - Widths of register addresses and Tuse/Tnew fields.
// - Forward-select encodings for the D-stage and E-stage operand muxes.
// - Tuse/Tnew constants per instruction class.
// - A saturating Tnew decrement used when an entry moves down the pipe.
package hazard_ctrl_pkg;

  localparam int RA_W    = 5;
  localparam int T_W     = 2;
  localparam int NUM_OPS = 2;  // rs, rt

  // D-stage mux: register file, E-stage result, M-stage result.
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  // E-stage mux: register, M-stage result, W-stage result.
  localparam logic [1:0] FWD_M_RES = 2'd1;
  localparam logic [1:0] FWD_W     = 2'd2;

  // Tuse: stage at which an operand is actually consumed.
  localparam logic [T_W-1:0] TUSE_D = 2'd0;  // branch compare, jr
  localparam logic [T_W-1:0] TUSE_E = 2'd1;  // ALU operand
  localparam logic [T_W-1:0] TUSE_M = 2'd2;  // store data

  // Tnew: cycles after E entry until the result exists.
  localparam logic [T_W-1:0] TNEW_JAL  = 2'd0;
  localparam logic [T_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [T_W-1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic [RA_W-1:0] dst;
    logic [T_W-1:0]  tnew;
  } trk_t;

  function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the decode stage and the hazard controller.
// - D_* : fields of the instruction currently in D (driven by the master).
// - stall/flush_E/fwd_* : control returned by the controller (slave).
interface hazard_ctrl_if #(
  parameter int RA_W = hazard_ctrl_pkg::RA_W,
  parameter int T_W  = hazard_ctrl_pkg::T_W
);
  logic [RA_W-1:0] D_rs;
  logic [RA_W-1:0] D_rt;
  logic            D_rs_used;
  logic            D_rt_used;
  logic [T_W-1:0]  D_tuse_rs;
  logic [T_W-1:0]  D_tuse_rt;
  logic [RA_W-1:0] D_dst;
  logic [T_W-1:0]  D_tnew;

  logic            stall;
  logic            flush_E;
  logic [1:0]      fwd_rs_D;
  logic [1:0]      fwd_rt_D;
  logic [1:0]      fwd_rs_E;
  logic [1:0]      fwd_rt_E;

  modport master (
    output D_rs, D_rt, D_rs_used, D_rt_used, D_tuse_rs, D_tuse_rt, D_dst, D_tnew,
    input  stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
  );

  modport slave (
    input  D_rs, D_rt, D_rs_used, D_rt_used, D_tuse_rs, D_tuse_rt, D_dst, D_tnew,
    output stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
  );
endinterface

// File: rtl/hazard_track_stage.sv
// One tracking entry: destination register and remaining Tnew of the
// instruction occupying a pipeline stage.
// - clk, rst    : clock, asynchronous active-high reset (clears entry)
// - bubble      : load an empty entry instead of the incoming one
// - dst_in/tnew_in : entry arriving from the stage above
// - dst/tnew    : current entry
// DEC=1 applies a saturating decrement to Tnew on load, modelling one
// cycle of progress between stages.
module hazard_track_stage
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = hazard_ctrl_pkg::RA_W,
  parameter int T_W  = hazard_ctrl_pkg::T_W,
  parameter bit DEC  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble,
  input  logic [RA_W-1:0] dst_in,
  input  logic [T_W-1:0]  tnew_in,
  output logic [RA_W-1:0] dst,
  output logic [T_W-1:0]  tnew
);

  logic [T_W-1:0] tnew_nxt;

  assign tnew_nxt = DEC ? tnew_dec(tnew_in) : tnew_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst  <= '0;
      tnew <= '0;
    end else if (bubble) begin
      dst  <= '0;
      tnew <= '0;
    end else begin
      dst  <= dst_in;
      tnew <= tnew_nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage F/D/E/M/W pipeline.
// - clk, reset : clock, asynchronous active-high reset (clears all tracking)
// - hz (slave) : D-stage operand/destination fields in; stall, flush_E and
//                the D/E operand mux selects out
// Tracks {dst,tnew} for E and M plus the source registers held in E, and
// dst alone for W. Stall and all selects are combinational from that state
// and the D-stage fields.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = hazard_ctrl_pkg::RA_W,
  parameter int T_W  = hazard_ctrl_pkg::T_W
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  logic [RA_W-1:0] e_dst, m_dst, w_dst;
  logic [T_W-1:0]  e_tnew, m_tnew;

  // Operand index 0 = rs, 1 = rt.
  logic [NUM_OPS-1:0][RA_W-1:0] d_op;
  logic [NUM_OPS-1:0][RA_W-1:0] e_op;
  logic [NUM_OPS-1:0]           d_used;
  logic [NUM_OPS-1:0][T_W-1:0]  d_tuse;
  logic [NUM_OPS-1:0]           op_stall;
  logic [NUM_OPS-1:0][1:0]      fwd_d;
  logic [NUM_OPS-1:0][1:0]      fwd_e;
  logic                         stall;

  assign d_op   = {hz.D_rt, hz.D_rs};
  assign d_used = {hz.D_rt_used, hz.D_rs_used};
  assign d_tuse = {hz.D_tuse_rt, hz.D_tuse_rs};

  // E entry takes the D instruction, or a bubble while D is held.
  hazard_track_stage #(.RA_W(RA_W), .T_W(T_W), .DEC(1'b0)) u_trk_e (
    .clk     (clk),
    .rst     (reset),
    .bubble  (stall),
    .dst_in  (hz.D_dst),
    .tnew_in (hz.D_tnew),
    .dst     (e_dst),
    .tnew    (e_tnew)
  );

  // M entry always advances from E; Tnew ticks down one cycle.
  hazard_track_stage #(.RA_W(RA_W), .T_W(T_W), .DEC(1'b1)) u_trk_m (
    .clk     (clk),
    .rst     (reset),
    .bubble  (1'b0),
    .dst_in  (e_dst),
    .tnew_in (e_tnew),
    .dst     (m_dst),
    .tnew    (m_tnew)
  );

  // Sources of the E instruction, needed for the E-stage forward selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      e_op <= '0;
    else if (stall) e_op <= '0;
    else            e_op <= d_op;
  end

  // Results in W are past every Tnew; only the address matters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_dst <= '0;
    else       w_dst <= m_dst;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_OPS; i++) begin : g_op
      logic d_nz, e_nz, d_hit_e, d_hit_m;

      // $0 is never a real destination, so a zero source can never match.
      assign d_nz    = (d_op[i] != '0);
      assign e_nz    = (e_op[i] != '0);
      assign d_hit_e = d_nz && (e_dst == d_op[i]);
      assign d_hit_m = d_nz && (m_dst == d_op[i]);

      // Stall while the producer's result arrives later than it is needed.
      assign op_stall[i] = d_used[i] &&
                           ((d_hit_e && (e_tnew > d_tuse[i])) ||
                            (d_hit_m && (m_tnew > d_tuse[i])));

      // Younger writer (E) wins over M; only ready results are forwarded.
      assign fwd_d[i] = (d_hit_e && (e_tnew == '0)) ? FWD_E :
                        (d_hit_m && (m_tnew == '0)) ? FWD_M : FWD_RF;

      assign fwd_e[i] = (e_nz && (m_dst == e_op[i])) ? FWD_M_RES :
                        (e_nz && (w_dst == e_op[i])) ? FWD_W     : FWD_RF;
    end
  endgenerate

  assign stall       = |op_stall;
  assign hz.stall    = stall;
  assign hz.flush_E  = stall;
  assign hz.fwd_rs_D = fwd_d[0];
  assign hz.fwd_rt_D = fwd_d[1];
  assign hz.fwd_rs_E = fwd_e[0];
  assign hz.fwd_rt_E = fwd_e[1];

endmodule
